// File: rtl/button_pulser.sv
// Two-button front end: synchronise and debounce each raw push-button, then turn
// every accepted press into one inc/dec pulse followed by timed auto-repeat.
module button_pulser #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc,
  output logic dec,
  output logic inc_held,
  output logic dec_held
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    WAIT,
    HOLD,
    LOCKOUT
  } state_t;

  logic [1:0] raw;
  logic [1:0] held;
  logic [1:0] pulse;

  assign raw      = {btn_dec_raw, btn_inc_raw};
  assign inc      = pulse[0];
  assign dec      = pulse[1];
  assign inc_held = held[0];
  assign dec_held = held[1];

  // Channel 0 is increment, channel 1 is decrement.
  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          db_cnt;
    logic                   held_r;
    logic [RW-1:0]          rep_cnt;
    logic                   pulse_r;
    state_t                 state;
    logic                   other_held;

    assign held[ch]   = held_r;
    assign pulse[ch]  = pulse_r;
    assign other_held = held[1-ch];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync   <= '0;
        db_cnt <= '0;
        held_r <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments let every stage capture its neighbour's
        // previous value, so this really is a SYNC_STAGES-deep flop chain.
        sync <= {sync[SYNC_STAGES-2:0], raw[ch]};
        if (sync[SYNC_STAGES-1] == held_r) begin
          db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYCLES)) begin
          held_r <= ~held_r;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        rep_cnt <= '0;
        pulse_r <= 1'b0;
      end else begin
        pulse_r <= 1'b0;
        if (state != IDLE && state != LOCKOUT && !held_r) begin
          state <= IDLE;
        end else if (state != LOCKOUT && held_r && other_held) begin
          state <= LOCKOUT;
        end else begin
          case (state)
            IDLE: begin
              if (held_r) begin
                state   <= FIRST;
                pulse_r <= 1'b1;
                rep_cnt <= RW'(REPEAT_DELAY);
              end
            end
            FIRST, WAIT: begin
              if (state == FIRST && REPEAT_DELAY == 0) begin
                state <= HOLD;
              end else begin
                state <= WAIT;
                // The counter was loaded on the pulse edge, so reaching 1 marks
                // exactly REPEAT_DELAY (then REPEAT_PERIOD) cycles since that pulse.
                if (rep_cnt == RW'(1)) begin
                  pulse_r <= 1'b1;
                  rep_cnt <= RW'(REPEAT_PERIOD);
                end else begin
                  rep_cnt <= rep_cnt - 1'b1;
                end
              end
            end
            HOLD:    state <= HOLD;
            LOCKOUT: if (!held_r && !other_held) state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_button_pulser.sv
// Bench for button_pulser: directed scenarios with fixed expected edges plus
// randomized button activity scored against a behavioural model every cycle.
`timescale 1ns/1ps
module tb_button_pulser;

  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 3;

  bit   clk;
  logic reset;
  logic btn_inc_raw;
  logic btn_dec_raw;
  logic inc;
  logic dec;
  logic inc_held;
  logic dec_held;

  button_pulser #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_PERIOD  (PERIOD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc        (inc),
    .dec        (dec),
    .inc_held   (inc_held),
    .dec_held   (dec_held)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic inc;
    logic dec;
    logic inc_held;
    logic dec_held;
  } obs_t;

  obs_t       exp_q[$];
  logic [1:0] hist[$];     // raw samples, index = edge number since reset
  logic [1:0] m_held;
  logic [1:0] m_prev;
  logic [1:0] m_pulse;
  bit         m_locked;
  bit   [1:0] m_active;
  int         m_start[2];
  int         m_t;
  int         m_d;
  bit         m_all;

  function automatic logic seen(input int ch, input int e);
    if (e < 0) return 1'b0;
    return hist[e][ch];
  endfunction

  // A level is accepted once the raw input has shown it on DEB+1 consecutive
  // samples, SYNC edges late; pulses fall at press start, +DELAY, then every PERIOD.
  task automatic model_step();
    if (reset) begin
      hist.delete();
      m_held   = '0;
      m_locked = 0;
      m_active = '0;
      exp_q.push_back('0);
    end else begin
      m_t = hist.size();
      hist.push_back({btn_dec_raw, btn_inc_raw});
      m_prev  = m_held;
      m_pulse = '0;
      if (m_locked) begin
        m_locked = (m_prev != 2'b00);
      end else if (m_prev == 2'b11) begin
        m_locked = 1;
        m_active = '0;
      end else begin
        for (int ch = 0; ch < 2; ch++) begin
          if (!m_prev[ch]) begin
            m_active[ch] = 0;
          end else if (!m_active[ch]) begin
            m_active[ch] = 1;
            m_start[ch]  = m_t;
            m_pulse[ch]  = 1'b1;
          end else if (DELAY > 0) begin
            m_d = m_t - m_start[ch];
            if (m_d >= DELAY && (m_d - DELAY) % PERIOD == 0) m_pulse[ch] = 1'b1;
          end
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        m_all = 1;
        for (int j = m_t - SYNC - DEB; j <= m_t - SYNC; j++)
          if (seen(ch, j) == m_held[ch]) m_all = 0;
        if (m_all) m_held[ch] = ~m_held[ch];
      end
      exp_q.push_back({m_pulse[0], m_pulse[1], m_held[0], m_held[1]});
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  obs_t mon_exp;
  obs_t mon_act;

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {inc, dec, inc_held, dec_held};
      check("cycle{inc,dec,inc_held,dec_held}", int'(mon_act), int'(mon_exp));
      check("exclusive", int'(inc & dec), 0);
    end
  end

  // ---------------- stimulus ----------------
  logic s_inc, s_dec, s_ih, s_dh;

  // Drives one edge's raw levels, then samples outputs on the following negedge.
  task automatic step(input logic ir, input logic dr);
    btn_inc_raw = ir;
    btn_dec_raw = dr;
    @(posedge clk);
    @(negedge clk);
    s_inc = inc;
    s_dec = dec;
    s_ih  = inc_held;
    s_dh  = dec_held;
    #1;
  endtask

  int rep_exp[6] = '{7, 17, 20, 23, 26, 29};

  initial begin
    int         pulses[$];
    int         run, e, rise_edge, fall_edge, dcount, hcount;
    int         rem[2];
    logic       lvl;
    logic [1:0] lvl2;

    reset       = 1'b1;
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;

    // Reset with random raw inputs.
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("reset_outputs", int'({s_inc, s_dec, s_ih, s_dh}), 0);
    end
    reset = 1'b0;
    repeat (10) step(1'b0, 1'b0);

    // Single press.
    rise_edge = -1;
    dcount    = 0;
    pulses.delete();
    for (int k = 0; k < 20; k++) begin
      step(k <= 7, 1'b0);
      if (s_inc) pulses.push_back(k);
      if (s_ih && rise_edge < 0) rise_edge = k;
      if (s_dec) dcount++;
    end
    check("single_count", pulses.size(), 1);
    check("single_edge", pulses.size() > 0 ? pulses[0] : -1, 7);
    check("single_held_rise", rise_edge, 6);
    check("single_no_dec", dcount, 0);

    // Bounce rejection: high and low runs of 1-3 cycles.
    hcount = 0;
    dcount = 0;
    lvl    = 1'b1;
    e      = 0;
    while (e < 40) begin
      run = $urandom_range(1, 3);
      for (int k = 0; k < run; k++) begin
        step(1'b0, lvl);
        e++;
        if (s_dh) hcount++;
        if (s_dec) dcount++;
      end
      lvl = ~lvl;
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      if (s_dh) hcount++;
      if (s_dec) dcount++;
    end
    check("bounce_held", hcount, 0);
    check("bounce_pulse", dcount, 0);

    // Auto-repeat.
    fall_edge = -1;
    pulses.delete();
    for (int k = 0; k < 40; k++) begin
      step(k <= 24, 1'b0);
      if (s_inc) pulses.push_back(k);
      if (k > 6 && !s_ih && fall_edge < 0) fall_edge = k;
    end
    check("repeat_count", pulses.size(), 6);
    for (int i = 0; i < 6; i++)
      check("repeat_edge", i < pulses.size() ? pulses[i] : -1, rep_exp[i]);
    check("repeat_held_fall", fall_edge, 31);

    // Lockout, then a fresh inc press.
    dcount = 0;
    pulses.delete();
    for (int k = 0; k <= 80; k++) begin
      step(k <= 60, k < 20);
      if (s_inc) pulses.push_back(k);
      if (s_dec) dcount++;
    end
    check("lockout_inc", pulses.size(), 0);
    check("lockout_dec", dcount, 0);
    pulses.delete();
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 1'b0);
      if (s_inc) pulses.push_back(k);
    end
    check("relock_count", pulses.size(), 1);
    check("relock_edge", pulses.size() > 0 ? pulses[0] : -1, 7);
    repeat (20) step(1'b0, 1'b0);

    // Reset mid-hold.
    for (int k = 0; k <= 15; k++) step(1'b1, 1'b0);
    check("rst_mid_pre_held", int'(s_ih), 1);
    reset = 1'b1;
    #1;
    check("rst_mid_now", int'({inc, dec, inc_held, dec_held}), 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset = 1'b0;
    pulses.delete();
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 1'b0);
      if (s_inc) pulses.push_back(k);
    end
    check("rst_mid_count", pulses.size(), 1);
    check("rst_mid_edge", pulses.size() > 0 ? pulses[0] : -1, 7);
    repeat (20) step(1'b0, 1'b0);

    // Randomized presses, bounces, overlaps and occasional resets.
    lvl2 = '0;
    rem  = '{0, 0};
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          lvl2[ch] = ~lvl2[ch];
          rem[ch]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
        end
        rem[ch]--;
      end
      reset = ($urandom_range(0, 399) == 0);
      step(lvl2[0], lvl2[1]);
    end
    reset = 1'b0;
    repeat (20) step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_pulser.md
Name: button_pulser

Overview:
- Front end for the up/down value counter: turns two raw, bouncing push-button inputs into clean single-cycle `inc`/`dec` request pulses.
- Synchronises and debounces each button, emits exactly one pulse per press, then auto-repeats at a controlled rate while the button is held.
- A fast clock or a bouncy press therefore never produces +2/+3 on a single press.
- Its outputs drive the counter's `inc`/`dec` inputs directly, on the same clock domain.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchroniser per button (minimum 2).
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised cycles required to accept a level change (minimum 1).
- REPEAT_DELAY, 25000000: cycles from the first pulse to the first auto-repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses (minimum 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_inc_raw  input  1  raw increment button, asynchronous, active-high when pressed.
- btn_dec_raw  input  1  raw decrement button, asynchronous, active-high when pressed.
- inc  output  1  one-cycle increment request pulse, registered.
- dec  output  1  one-cycle decrement request pulse, registered.
- inc_held  output  1  debounced pressed state of the increment button.
- dec_held  output  1  debounced pressed state of the decrement button.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0.
  - Synchroniser flops, debounce counters and repeat counters clear to 0.
  - Both FSMs go to IDLE.
- Synchroniser: per button, a SYNC_STAGES-deep flop chain; only the last stage feeds the debounce logic.
- Debounce: per button, one stable flag (= `*_held`) and one counter sized with $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised level equals the stable flag.
  - Otherwise the counter increments.
  - On the cycle the count would reach DEBOUNCE_CYCLES, the stable flag toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable flag.
- Latency: raw rising level first sampled at edge 0 -> `*_held`=1 at edge SYNC_STAGES+DEBOUNCE_CYCLES -> first pulse at edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Release latency is identical.
- Per-channel FSM (inc and dec each have one), with a repeat counter sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - IDLE: on `held`=1, go to FIRST.
  - FIRST: assert the pulse for exactly this one cycle.
    - If REPEAT_DELAY=0, go to HOLD.
    - Otherwise load the counter with REPEAT_DELAY and go to WAIT.
  - WAIT: decrement the counter. When it reaches 1, the next cycle pulses and the counter reloads with REPEAT_PERIOD. Pulses are therefore spaced exactly REPEAT_DELAY, then REPEAT_PERIOD, cycles apart.
  - HOLD: no pulses; stay until release.
  - From any non-IDLE state, `held`=0 returns the FSM to IDLE in the same cycle; no pulse is emitted on release.
- Mutual exclusion:
  - `inc` and `dec` are never 1 in the same cycle.
  - If both `held` flags are 1 simultaneously, both FSMs enter LOCKOUT.
  - In LOCKOUT, no pulses are emitted until both `held` flags are 0; then both FSMs return to IDLE.
  - A button still held when the other is released does not pulse until it is itself released and pressed again.
- Reset mid-press:
  - All state and outputs clear immediately.
  - After reset deasserts with a button still physically held, that button is re-accepted through the full latency and treated as a new press (first pulse, then repeat).
- Pulses are level-independent of the downstream counter's saturation; clamping at 0/255 is the counter's job.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3. Edge 0 is the first edge sampling the raw high.
- Reset: assert `reset` with random raw inputs -> `inc`, `dec`, `inc_held`, `dec_held` all 0 immediately and held while reset is asserted.
- Single press: `btn_inc_raw` high for edges 0-7, then low -> `inc_held` rises at edge 6; exactly one `inc` pulse at edge 7; `dec` stays 0 throughout.
- Bounce rejection: `btn_dec_raw` toggled with high runs of 1-3 cycles for 40 cycles -> `dec_held` stays 0 and no `dec` pulse.
- Auto-repeat: `btn_inc_raw` high for edges 0-24, low from 25 -> `inc` pulses at exactly edges 7, 17, 20, 23, 26, 29; `inc_held` falls at edge 31; no pulse at 32 or later.
- Lockout: both raw inputs high from edge 0; release `btn_dec_raw` at edge 20, keep `btn_inc_raw` high to edge 60 -> no `inc`/`dec` pulses anywhere; then release and re-press inc -> normal first pulse after 7 cycles.
- Reset mid-hold: `btn_inc_raw` held; pulse `reset` at edge 15 for 2 cycles -> outputs 0 immediately; next `inc` pulse at exactly 7 edges after reset deassertion.
